// File: rtl/snn_decoder_pkg.sv
// Shared definitions for the SNN motor-command rate decoder:
// turn codes carried on cmd_turn and the window FSM state encoding.
package snn_decoder_pkg;

    localparam logic [1:0] TURN_STOP  = 2'b00;
    localparam logic [1:0] TURN_LEFT  = 2'b01;
    localparam logic [1:0] TURN_RIGHT = 2'b10;
    localparam logic [1:0] TURN_FWD   = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/spike_rate_counter.sv
// Saturating per-channel spike counter for one decoding window.
// rate_next is the count including the current cycle's spike, so the
// decision at the last window cycle sees that cycle's spike as well.
module spike_rate_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             win_end,
    input  logic             clr,
    input  logic             spike,
    output logic [WIDTH-1:0] rate_next
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] sum_s;

    // Next count: add an accepted spike unless already at the ceiling.
    always_comb begin
        sum_s = count_r;
        if (cnt_en && spike && (count_r != CNT_MAX)) begin
            sum_s = count_r + CNT_ONE;
        end else begin
            sum_s = count_r;
        end
    end

    // Count register: cleared on reset, on window end and when the network is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (clr || win_end) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= sum_s;
        end
    end

    assign rate_next = sum_s;

endmodule

// File: rtl/snn_motor_decoder.sv
// Rate decoder behind the sensor-to-motor SNN: counts Left/Right spikes over
// a window of 2**WIN_LOG2 enabled cycles and emits one motor command per
// window on a valid/ready handshake.
// Optional feature: define SNN_PWM_OUT_EN to add pwm_l/pwm_r duty outputs.
module snn_motor_decoder
    import snn_decoder_pkg::*;
#(
    parameter int EXCNUM   = 2,
    parameter int WIN_LOG2 = 4,
    parameter int MARGIN   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [EXCNUM-1:0]   spike_in,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [WIN_LOG2-1:0] cmd_rate_l,
    output logic [WIN_LOG2-1:0] cmd_rate_r,
    output logic [1:0]          cmd_turn,
    output logic                cmd_drop
`ifdef SNN_PWM_OUT_EN
    ,
    output logic                pwm_l,
    output logic                pwm_r
`endif
);

    localparam logic [WIN_LOG2-1:0] W_ZERO     = {WIN_LOG2{1'b0}};
    localparam logic [WIN_LOG2-1:0] W_ONE      = {{(WIN_LOG2-1){1'b0}}, 1'b1};
    localparam logic [WIN_LOG2-1:0] WCNT_LAST  = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2:0]   MARGIN_EXT = (WIN_LOG2+1)'(MARGIN);

    fsm_state_t          state_r;
    fsm_state_t          state_s;
    logic                cnt_en_s;
    logic                clr_s;
    logic                win_end_s;
    logic [WIN_LOG2-1:0] wcnt_r;

    logic [WIN_LOG2-1:0] rate_l_s;
    logic [WIN_LOG2-1:0] rate_r_s;
    logic [WIN_LOG2:0]   ext_l_s;
    logic [WIN_LOG2:0]   ext_r_s;
    logic [1:0]          turn_s;

    logic                load_s;
    logic                drop_s;
    logic                valid_r;
    logic [WIN_LOG2-1:0] rate_l_r;
    logic [WIN_LOG2-1:0] rate_r_r;
    logic [1:0]          turn_r;
    logic                drop_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and per-cycle control: the IDLE->COUNT cycle is not counted,
    // dropping en inside COUNT discards the partial window.
    always_comb begin
        state_s   = state_r;
        cnt_en_s  = 1'b0;
        clr_s     = 1'b0;
        win_end_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_s = COUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (en) begin
                    state_s   = COUNT;
                    cnt_en_s  = 1'b1;
                    win_end_s = (wcnt_r == WCNT_LAST);
                end else begin
                    state_s = IDLE;
                    clr_s   = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                clr_s   = 1'b1;
            end
        endcase
    end

    // Window position: wraps naturally after the last cycle so windows abut.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_r <= W_ZERO;
        end else if (clr_s) begin
            wcnt_r <= W_ZERO;
        end else if (cnt_en_s) begin
            wcnt_r <= wcnt_r + W_ONE;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    spike_rate_counter #(.WIDTH(WIN_LOG2)) u_cnt_l (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    (cnt_en_s),
        .win_end   (win_end_s),
        .clr       (clr_s),
        .spike     (spike_in[0]),
        .rate_next (rate_l_s)
    );

    spike_rate_counter #(.WIDTH(WIN_LOG2)) u_cnt_r (
        .clk       (clk),
        .rst       (rst),
        .cnt_en    (cnt_en_s),
        .win_end   (win_end_s),
        .clr       (clr_s),
        .spike     (spike_in[1]),
        .rate_next (rate_r_s)
    );

    assign ext_l_s = {1'b0, rate_l_s};
    assign ext_r_s = {1'b0, rate_r_s};

    // Turn decision on the final window counts, one extra bit so rate+MARGIN cannot wrap.
    always_comb begin
        turn_s = TURN_FWD;
        if ((rate_l_s == W_ZERO) && (rate_r_s == W_ZERO)) begin
            turn_s = TURN_STOP;
        end else if (ext_l_s > (ext_r_s + MARGIN_EXT)) begin
            turn_s = TURN_LEFT;
        end else if (ext_r_s > (ext_l_s + MARGIN_EXT)) begin
            turn_s = TURN_RIGHT;
        end else begin
            turn_s = TURN_FWD;
        end
    end

    // A finished window loads if the slot is empty or being drained this cycle, otherwise it is dropped.
    always_comb begin
        load_s = 1'b0;
        drop_s = 1'b0;
        if (win_end_s) begin
            load_s = (!valid_r) || cmd_ready;
            drop_s = valid_r && !cmd_ready;
        end else begin
            load_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Command output register with valid/ready handshake and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= 1'b0;
            rate_l_r <= W_ZERO;
            rate_r_r <= W_ZERO;
            turn_r   <= TURN_STOP;
            drop_r   <= 1'b0;
        end else begin
            drop_r <= drop_s;
            if (load_s) begin
                valid_r  <= 1'b1;
                rate_l_r <= rate_l_s;
                rate_r_r <= rate_r_s;
                turn_r   <= turn_s;
            end else if (valid_r && cmd_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign cmd_valid  = valid_r;
    assign cmd_rate_l = rate_l_r;
    assign cmd_rate_r = rate_r_r;
    assign cmd_turn   = turn_r;
    assign cmd_drop   = drop_r;

`ifdef SNN_PWM_OUT_EN
    logic [WIN_LOG2-1:0] pwm_cnt_r;
    logic [WIN_LOG2-1:0] duty_l_r;
    logic [WIN_LOG2-1:0] duty_r_r;
    logic                pwm_l_r;
    logic                pwm_r_r;

    // Free-running PWM carrier plus duty taken from every loaded command.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_r <= W_ZERO;
            duty_l_r  <= W_ZERO;
            duty_r_r  <= W_ZERO;
            pwm_l_r   <= 1'b0;
            pwm_r_r   <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + W_ONE;
            pwm_l_r   <= (pwm_cnt_r < duty_l_r);
            pwm_r_r   <= (pwm_cnt_r < duty_r_r);
            if (load_s) begin
                duty_l_r <= rate_l_s;
                duty_r_r <= rate_r_s;
            end else begin
                duty_l_r <= duty_l_r;
                duty_r_r <= duty_r_r;
            end
        end
    end

    assign pwm_l = pwm_l_r;
    assign pwm_r = pwm_r_r;
`else
    // No PWM outputs in this build; the command interface alone drives the motor controller.
`endif

endmodule

// File: tb/tb_snn_motor_decoder.sv
// Self-checking bench for snn_motor_decoder (WIN_LOG2=4, MARGIN=2):
// directed scenarios followed by randomized traffic, all against a
// cycle-level behavioural model of windows, counts and the command slot.
module tb_snn_motor_decoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] spike_in;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_rate_l;
    logic [3:0] cmd_rate_r;
    logic [1:0] cmd_turn;
    logic       cmd_drop;
`ifdef SNN_PWM_OUT_EN
    logic       pwm_l;
    logic       pwm_r;
`endif

    snn_motor_decoder #(.EXCNUM(2), .WIN_LOG2(4), .MARGIN(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rate_l (cmd_rate_l),
        .cmd_rate_r (cmd_rate_r),
        .cmd_turn   (cmd_turn),
        .cmd_drop   (cmd_drop)
`ifdef SNN_PWM_OUT_EN
        ,
        .pwm_l      (pwm_l),
        .pwm_r      (pwm_r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: plain integers describing windows and the command slot.
    int m_on, m_pos, m_l, m_r;
    int m_valid, m_rl, m_rr, m_turn, m_drop;
    int m_pcnt, m_dl, m_dr, m_pwm_l, m_pwm_r;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int turn_of(input int l, input int r);
        if (l == 0 && r == 0) return 0;
        if (l > r + 2) return 1;
        if (r > l + 2) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_on = 0; m_pos = 0; m_l = 0; m_r = 0;
        m_valid = 0; m_rl = 0; m_rr = 0; m_turn = 0; m_drop = 0;
        m_pcnt = 0; m_dl = 0; m_dr = 0; m_pwm_l = 0; m_pwm_r = 0;
    endtask

    task automatic model_update(input logic r, input logic e, input logic [1:0] s, input logic rdy);
        int  fl, fr;
        bit  done;
        done = 1'b0;
        fl = 0;
        fr = 0;
        if (r) begin
            model_reset();
            return;
        end
        m_pwm_l = (m_pcnt < m_dl) ? 1 : 0;
        m_pwm_r = (m_pcnt < m_dr) ? 1 : 0;
        m_pcnt  = (m_pcnt + 1) % 16;
        m_drop  = 0;
        if (m_on == 0) begin
            m_on = e ? 1 : 0;
        end else if (!e) begin
            m_on = 0; m_pos = 0; m_l = 0; m_r = 0;
        end else begin
            if (s[0]) m_l = (m_l + 1 > 15) ? 15 : m_l + 1;
            if (s[1]) m_r = (m_r + 1 > 15) ? 15 : m_r + 1;
            if (m_pos == 15) begin
                done = 1'b1; fl = m_l; fr = m_r;
                m_pos = 0; m_l = 0; m_r = 0;
            end else begin
                m_pos++;
            end
        end
        if (done) begin
            if (m_valid == 0 || rdy) begin
                m_valid = 1; m_rl = fl; m_rr = fr; m_turn = turn_of(fl, fr);
                m_dl = fl; m_dr = fr;
            end else begin
                m_drop = 1;
            end
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] s, input logic rdy);
        rst = r; en = e; spike_in = s; cmd_ready = rdy;
        @(posedge clk);
        model_update(r, e, s, rdy);
        #1;
        check_eq("valid", cmd_valid, m_valid);
        check_eq("rate_l", cmd_rate_l, m_rl);
        check_eq("rate_r", cmd_rate_r, m_rr);
        check_eq("turn", cmd_turn, m_turn);
        check_eq("drop", cmd_drop, m_drop);
`ifdef SNN_PWM_OUT_EN
        check_eq("pwm_l", pwm_l, m_pwm_l);
        check_eq("pwm_r", pwm_r, m_pwm_r);
`endif
    endtask

    // n cycles; left spikes in the first nl of them, right in the first nr.
    task automatic run(input int n, input int nl, input int nr, input logic e, input logic rdy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, e, {(i < nr), (i < nl)}, rdy);
        end
    endtask

    initial begin
        int dens;
        int highs;
        model_reset();
        rst = 1'b1; en = 1'b0; spike_in = 2'b00; cmd_ready = 1'b0;

        // 1: reset held with spikes toggling
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, (i % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
        check_eq("rst_valid", cmd_valid, 1'b0);
        check_eq("rst_turn", cmd_turn, 2'd0);
        step(1'b0, 1'b0, 2'b00, 1'b1);

        // 2: left every cycle -> saturated 15, LEFT
        step(1'b0, 1'b1, 2'b01, 1'b1);
        run(16, 16, 0, 1'b1, 1'b1);
        check_eq("sat_valid", cmd_valid, 1'b1);
        check_eq("sat_rate_l", cmd_rate_l, 4'd15);
        check_eq("sat_rate_r", cmd_rate_r, 4'd0);
        check_eq("sat_turn", cmd_turn, 2'b01);

        // 3: 5/6 -> FORWARD, valid lasts one cycle with ready=1
        run(1, 1, 1, 1'b1, 1'b1);
        check_eq("one_cycle_valid", cmd_valid, 1'b0);
        run(15, 4, 5, 1'b1, 1'b1);
        check_eq("fwd_rate_l", cmd_rate_l, 4'd5);
        check_eq("fwd_rate_r", cmd_rate_r, 4'd6);
        check_eq("fwd_turn", cmd_turn, 2'b11);
        run(16, 2, 9, 1'b1, 1'b1);
        check_eq("right_turn", cmd_turn, 2'b10);

        // 4: silent window -> STOP, next window without a gap
        run(16, 0, 0, 1'b1, 1'b1);
        check_eq("stop_turn", cmd_turn, 2'b00);
        check_eq("stop_rate_l", cmd_rate_l, 4'd0);
        run(16, 3, 0, 1'b1, 1'b1);
        check_eq("nogap_valid", cmd_valid, 1'b1);
        check_eq("nogap_rate_l", cmd_rate_l, 4'd3);

        // 5: back-pressure across a window end -> drop, old payload held
        run(16, 4, 4, 1'b1, 1'b1);
        run(16, 7, 1, 1'b1, 1'b0);
        check_eq("bp_drop", cmd_drop, 1'b1);
        check_eq("bp_valid", cmd_valid, 1'b1);
        check_eq("bp_rate_l", cmd_rate_l, 4'd4);
        check_eq("bp_turn", cmd_turn, 2'b11);
        run(1, 0, 0, 1'b1, 1'b1);
        check_eq("bp_xfer", cmd_valid, 1'b0);
        check_eq("bp_drop_once", cmd_drop, 1'b0);

        // 6: en low at window cycle 8 discards the partial window
        run(7, 0, 0, 1'b1, 1'b1);
        run(1, 0, 0, 1'b0, 1'b1);
        run(4, 0, 0, 1'b0, 1'b1);
        check_eq("abort_valid", cmd_valid, 1'b0);
        run(1, 0, 0, 1'b1, 1'b1);
        run(15, 4, 0, 1'b1, 1'b0);
        check_eq("restart_early", cmd_valid, 1'b0);
        run(1, 0, 0, 1'b1, 1'b0);
        check_eq("restart_valid", cmd_valid, 1'b1);
        check_eq("restart_rate_l", cmd_rate_l, 4'd4);
        check_eq("restart_turn", cmd_turn, 2'b01);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 2'b00, 1'b0);
`ifdef SNN_PWM_OUT_EN
            if (pwm_l) highs++;
`endif
        end
`ifdef SNN_PWM_OUT_EN
        check_eq("pwm_duty4", highs, 4);
`endif
        check_eq("hold_en_low", cmd_valid, 1'b1);

        // Randomized traffic with occasional resets
        dens = 2;
        for (int i = 0; i < 4000; i++) begin
            if (i % 16 == 0) dens = $urandom_range(0, 4);
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 19) != 0),
                 {($urandom_range(0, 3) < dens), ($urandom_range(0, 3) < dens)},
                 ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
